// File: rtl/cpu_pkg.sv
// Shared fetch-side types, widths and branch-offset helpers.
// Combinational only; no latency or backpressure.
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

   // B/BL word offset -> signed byte offset
   function automatic logic [ADDR_W-1:0] sext_br_off(input logic [25:0] off);
      return {{(ADDR_W-28){off[25]}}, off, 2'b00};
   endfunction

   // B.cond/CBZ word offset -> signed byte offset
   function automatic logic [ADDR_W-1:0] sext_cond_off(input logic [18:0] off);
      return {{(ADDR_W-21){off[18]}}, off, 2'b00};
   endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Branch target mux/adder for BR, B/BL and B.cond/CBZ; purely combinational.
// Zero latency, no handshake; result is always word aligned.
module branch_target_calc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = cpu_pkg::ADDR_W
)
(
   input  logic [ADDR_W-1:0] branch_pc,
   input  logic              UnCondBr,
   input  logic              BRsignal,
   input  logic [25:0]       BR_addr,
   input  logic [18:0]       COND_BR_addr,
   input  logic [ADDR_W-1:0] br_reg_target,
   output logic [ADDR_W-1:0] target
);

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] raw;

   always_comb begin
      offset = UnCondBr ? ADDR_W'(sext_br_off(BR_addr))
                        : ADDR_W'(sext_cond_off(COND_BR_addr));
      raw    = BRsignal ? br_reg_target : (branch_pc + offset);
      target = raw;
      target[1:0] = 2'b00;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner: one outstanding imem request, one-entry instruction buffer to the decoder.
// 3 cycles/instr with zero-latency memory; holds output until instr_ready, redirect flushes.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = cpu_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_plus4,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  branch_pc,
   input  logic               UnCondBr,
   input  logic               BRsignal,
   input  logic [25:0]        BR_addr,
   input  logic [18:0]        COND_BR_addr,
   input  logic [ADDR_W-1:0]  br_reg_target
);

   fetch_state_t       state, state_nxt;
   logic [ADDR_W-1:0]  fetch_addr, fetch_addr_nxt;
   logic [ADDR_W-1:0]  pc_nxt, pc_plus4_nxt;
   logic [INSTR_W-1:0] instruction_nxt;
   logic               instr_valid_nxt;
   logic [ADDR_W-1:0]  target;
   logic               req_hs;
   logic               instr_hs;

   branch_target_calc #(.ADDR_W(ADDR_W)) u_target (
      .branch_pc     (branch_pc),
      .UnCondBr      (UnCondBr),
      .BRsignal      (BRsignal),
      .BR_addr       (BR_addr),
      .COND_BR_addr  (COND_BR_addr),
      .br_reg_target (br_reg_target),
      .target        (target)
   );

   assign imem_req_valid = (state == FETCH) && !reset;
   assign imem_req_addr  = fetch_addr;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign instr_hs       = instr_valid && instr_ready;

   // Redirect wins over every sequential update in every state.
   always_comb begin
      state_nxt       = state;
      fetch_addr_nxt  = fetch_addr;
      instr_valid_nxt = instr_valid;
      instruction_nxt = instruction;
      pc_nxt          = pc;
      pc_plus4_nxt    = pc_plus4;
      case (state)
         FETCH: begin
            if (redirect) begin
               fetch_addr_nxt = target;
               state_nxt      = req_hs ? DROP : FETCH;
            end else if (req_hs) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               fetch_addr_nxt = target;
               state_nxt      = imem_resp_valid ? FETCH : DROP;
            end else if (imem_resp_valid) begin
               instruction_nxt = imem_resp_data;
               pc_nxt          = fetch_addr;
               pc_plus4_nxt    = fetch_addr + ADDR_W'(4);
               instr_valid_nxt = 1'b1;
               state_nxt       = HOLD;
            end
         end
         HOLD: begin
            if (redirect) begin
               instr_valid_nxt = 1'b0;
               fetch_addr_nxt  = target;
               state_nxt       = FETCH;
            end else if (instr_hs) begin
               instr_valid_nxt = 1'b0;
               fetch_addr_nxt  = pc_plus4;
               state_nxt       = FETCH;
            end
         end
         DROP: begin
            // Stale response still owed by memory; swallow it before refetching.
            if (redirect) begin
               fetch_addr_nxt = target;
            end
            if (imem_resp_valid) begin
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         fetch_addr  <= RESET_PC;
         instr_valid <= 1'b0;
         instruction <= '0;
         pc          <= RESET_PC;
         pc_plus4    <= RESET_PC + ADDR_W'(4);
      end else begin
         state       <= state_nxt;
         fetch_addr  <= fetch_addr_nxt;
         instr_valid <= instr_valid_nxt;
         instruction <= instruction_nxt;
         pc          <= pc_nxt;
         pc_plus4    <= pc_plus4_nxt;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench for instruction_fetch_unit with a latency-programmable memory model.
module tb_instruction_fetch_unit;

   localparam int              AW     = 64;
   localparam logic [AW-1:0]   RST_PC = '0;

   logic          clk = 1'b0;
   logic          reset;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_req_addr;
   logic          imem_resp_valid;
   logic [31:0]   imem_resp_data;
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instruction;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_plus4;
   logic          redirect;
   logic [AW-1:0] branch_pc;
   logic          UnCondBr;
   logic          BRsignal;
   logic [25:0]   BR_addr;
   logic [18:0]   COND_BR_addr;
   logic [AW-1:0] br_reg_target;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instruction     (instruction),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .redirect        (redirect),
      .branch_pc       (branch_pc),
      .UnCondBr        (UnCondBr),
      .BRsignal        (BRsignal),
      .BR_addr         (BR_addr),
      .COND_BR_addr    (COND_BR_addr),
      .br_reg_target   (br_reg_target)
   );

   typedef struct {
      logic [AW-1:0] pc;
      logic [31:0]   ins;
   } exp_t;

   int            tests = 0;
   int            fails = 0;
   int            mem_lat = 0;
   int            instr_hs_cnt = 0;
   logic [AW-1:0] req_q[$];
   exp_t          ins_q[$];

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [AW-1:0] a);
      req_q.push_back(a);
   endtask

   task automatic push_instr(input logic [AW-1:0] a);
      exp_t e;
      e.pc  = a;
      e.ins = mem_word(a);
      ins_q.push_back(e);
   endtask

   // Memory: accepts a request, answers after mem_lat extra cycles, cleared by reset.
   initial begin : mem_model
      logic          hs;
      logic          rst;
      logic          pend;
      logic [AW-1:0] addr;
      logic [AW-1:0] paddr;
      int            cnt;
      pend = 1'b0;
      paddr = '0;
      cnt = 0;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      forever begin
         @(negedge clk);
         hs   = imem_req_valid && imem_req_ready;
         rst  = reset;
         addr = imem_req_addr;
         if (hs && pend && !rst) begin
            fails++;
            $display("FAIL two_outstanding addr=%h while %h pending", addr, paddr);
         end
         @(posedge clk);
         #1;
         imem_resp_valid = 1'b0;
         if (rst) pend = 1'b0;
         else if (hs) begin
            pend  = 1'b1;
            paddr = addr;
            cnt   = mem_lat;
         end
         if (pend) begin
            if (cnt == 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_word(paddr);
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Scoreboard: every request and every decoder handshake must match a queued expectation.
   initial begin : monitor
      logic [AW-1:0] ea;
      exp_t          ei;
      forever begin
         @(negedge clk);
         if (!reset && imem_req_valid && imem_req_ready) begin
            tests++;
            if (req_q.size() == 0) begin
               fails++;
               $display("FAIL req_unexpected got addr=%h expected none", imem_req_addr);
            end else begin
               ea = req_q.pop_front();
               if (imem_req_addr !== ea) begin
                  fails++;
                  $display("FAIL req_addr got %h expected %h", imem_req_addr, ea);
               end
            end
         end
         if (!reset && instr_valid && instr_ready) begin
            instr_hs_cnt++;
            tests++;
            if (ins_q.size() == 0) begin
               fails++;
               $display("FAIL instr_unexpected got pc=%h expected none", pc);
            end else begin
               ei = ins_q.pop_front();
               if (pc !== ei.pc || instruction !== ei.ins || pc_plus4 !== ei.pc + 64'd4) begin
                  fails++;
                  $display("FAIL instr_out got pc=%h ins=%h pc4=%h expected pc=%h ins=%h pc4=%h",
                           pc, instruction, pc_plus4, ei.pc, ei.ins, ei.pc + 64'd4);
               end
            end
         end
      end
   end

   // From FETCH at address a (req_ready low): fetch and retire one instruction, then park in FETCH.
   task automatic fetch_one(input logic [AW-1:0] a);
      int start;
      push_req(a);
      push_instr(a);
      start = instr_hs_cnt;
      instr_ready = 1'b1;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 40 && instr_hs_cnt == start; i++) @(posedge clk);
      #1;
      imem_req_ready = 1'b0;
      tests++;
      if (instr_hs_cnt == start) begin
         fails++;
         $display("FAIL fetch_one_timeout got 0 handshakes expected 1 for addr=%h", a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      imem_req_ready = 1'b0;
      instr_ready = 1'b1;
      redirect = 1'b0;
      branch_pc = '0;
      UnCondBr = 1'b0;
      BRsignal = 1'b0;
      BR_addr = '0;
      COND_BR_addr = '0;
      br_reg_target = '0;
      repeat (3) tick();
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 ||
          pc !== RST_PC || pc_plus4 !== RST_PC + 64'd4) begin
         fails++;
         $display("FAIL reset_state got rv=%b iv=%b ins=%h pc=%h pc4=%h expected 0 0 0 %h %h",
                  imem_req_valid, instr_valid, instruction, pc, pc_plus4, RST_PC, RST_PC + 64'd4);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         fails++;
         $display("FAIL reset_release got rv=%b addr=%h expected 1 %h",
                  imem_req_valid, imem_req_addr, RST_PC);
      end
      tick();
   endtask

   task automatic test_sequential();
      int t[$];
      int cyc;
      for (int k = 0; k < 3; k++) begin
         push_req(64'(4 * k));
         push_instr(64'(4 * k));
      end
      instr_ready = 1'b1;
      imem_req_ready = 1'b1;
      cyc = 0;
      while (t.size() < 3 && cyc < 40) begin
         @(negedge clk);
         if (instr_valid) t.push_back(cyc);
         cyc++;
      end
      tick();
      imem_req_ready = 1'b0;
      tests++;
      if (t.size() != 3) begin
         fails++;
         $display("FAIL seq_count got %0d instrs expected 3", t.size());
      end else begin
         tests++;
         if (t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
            fails++;
            $display("FAIL seq_spacing got %0d,%0d cycles expected 3,3", t[1] - t[0], t[2] - t[1]);
         end
      end
   endtask

   task automatic test_hold_stall();
      push_req(64'hC);
      push_instr(64'hC);
      instr_ready = 1'b0;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 20 && !instr_valid; i++) tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (instr_valid !== 1'b1 || instruction !== mem_word(64'hC) || pc !== 64'hC ||
             imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_stable got iv=%b ins=%h pc=%h rv=%b expected 1 %h c 0",
                     instr_valid, instruction, pc, imem_req_valid, mem_word(64'hC));
         end
      end
      tick();
      instr_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10) begin
         fails++;
         $display("FAIL hold_next_addr got rv=%b addr=%h expected 1 10", imem_req_valid, imem_req_addr);
      end
      tick();
   endtask

   task automatic test_redirect_wait_drop();
      mem_lat = 2;
      push_req(64'h10);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect = 1'b1;
      BRsignal = 1'b0;
      UnCondBr = 1'b0;
      COND_BR_addr = 19'h1;
      branch_pc = 64'h200;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL wait_no_req got rv=%b expected 0", imem_req_valid);
      end
      tick();
      UnCondBr = 1'b1;
      BR_addr = 26'h3FFFFFE;
      COND_BR_addr = '0;
      branch_pc = 64'h40;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL drop_hold got rv=%b expected 0", imem_req_valid);
      end
      tick();
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h38 || instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL drop_target got rv=%b addr=%h iv=%b expected 1 38 0",
                  imem_req_valid, imem_req_addr, instr_valid);
      end
      tick();
      mem_lat = 0;
      UnCondBr = 1'b0;
      BR_addr = '0;
      branch_pc = '0;
   endtask

   task automatic test_redirect_hold();
      push_req(64'h38);
      instr_ready = 1'b0;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 20 && !instr_valid; i++) tick();
      imem_req_ready = 1'b0;
      redirect = 1'b1;
      BRsignal = 1'b1;
      UnCondBr = 1'b1;
      br_reg_target = 64'h1003;
      @(negedge clk);
      tests++;
      if (instr_valid !== 1'b1 || pc !== 64'h38) begin
         fails++;
         $display("FAIL hold_before_redirect got iv=%b pc=%h expected 1 38", instr_valid, pc);
      end
      tick();
      redirect = 1'b0;
      BRsignal = 1'b0;
      UnCondBr = 1'b0;
      @(negedge clk);
      tests++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
         fails++;
         $display("FAIL hold_redirect got iv=%b rv=%b addr=%h expected 0 1 1000",
                  instr_valid, imem_req_valid, imem_req_addr);
      end
      tick();
      instr_ready = 1'b1;
   endtask

   task automatic test_redirect_resp();
      push_req(64'h1000);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect = 1'b1;
      BRsignal = 1'b0;
      UnCondBr = 1'b0;
      COND_BR_addr = 19'h00010;
      branch_pc = 64'h100;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h140 || instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL wait_resp_redirect got rv=%b addr=%h iv=%b expected 1 140 0",
                  imem_req_valid, imem_req_addr, instr_valid);
      end
      tick();
   endtask

   task automatic test_redirect_fetch_hs();
      push_req(64'h140);
      imem_req_ready = 1'b1;
      redirect = 1'b1;
      BRsignal = 1'b1;
      br_reg_target = 64'h80;
      tick();
      imem_req_ready = 1'b0;
      redirect = 1'b0;
      BRsignal = 1'b0;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL fetch_hs_drop got rv=%b expected 0", imem_req_valid);
      end
      tick();
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80) begin
         fails++;
         $display("FAIL fetch_hs_target got rv=%b addr=%h expected 1 80", imem_req_valid, imem_req_addr);
      end
      tick();
   endtask

   task automatic test_wrap();
      redirect = 1'b1;
      BRsignal = 1'b1;
      br_reg_target = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      redirect = 1'b0;
      BRsignal = 1'b0;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         fails++;
         $display("FAIL fetch_redirect got rv=%b addr=%h expected 1 fffffffffffffffc",
                  imem_req_valid, imem_req_addr);
      end
      tick();
      fetch_one(64'hFFFF_FFFF_FFFF_FFFC);
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
         fails++;
         $display("FAIL wrap_addr got rv=%b addr=%h expected 1 0", imem_req_valid, imem_req_addr);
      end
      tick();
   endtask

   task automatic test_reset_wait();
      mem_lat = 3;
      push_req(64'h0);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_req_low got rv=%b expected 0", imem_req_valid);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_wait_release got rv=%b addr=%h iv=%b expected 1 %h 0",
                  imem_req_valid, imem_req_addr, instr_valid, RST_PC);
      end
      tick();
      mem_lat = 0;
      fetch_one(RST_PC);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequential();
      test_hold_stall();
      test_redirect_wait_drop();
      test_redirect_hold();
      test_redirect_resp();
      test_redirect_fetch_hs();
      test_wrap();
      test_reset_wait();
      repeat (3) tick();
      tests++;
      if (req_q.size() != 0 || ins_q.size() != 0) begin
         fails++;
         $display("FAIL queues_drained got req=%0d instr=%0d expected 0 0", req_q.size(), ins_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
